fp_divsqrt_iter: RTL and testbench

Multi-cycle iterative mantissa divide/square-root engine that sits directly upstream of the FPU normalise/round stage. It also generates the divide/sqrt stall (st_ds) and the iteration counters that the pipelined FPU exports.
- It accepts an fdiv or fsqrt issued from the E1 operand stage.
- It holds the operands and produces one quotient/root bit per cycle.
- It hands an unrounded mantissa, an exponent and a sticky bit to the rounding stage with a one-cycle done pulse.

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fp_divsqrt_iter_if.sv | 24 ++
 rtl/fp_unpack.sv | 16 +
 rtl/fp_divsqrt_iter.sv | 133 +++++++++++++
 tb/tb_fp_divsqrt_iter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared encodings for the divide/sqrt engine: op codes, special-result codes,
// FSM states and the unpacked-operand record.
package fpu_pkg;
  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_SQRT = 1'b1;

  localparam logic [1:0] SPC_NORM = 2'b00;
  localparam logic [1:0] SPC_ZERO = 2'b01;
  localparam logic [1:0] SPC_INF  = 2'b10;
  localparam logic [1:0] SPC_NAN  = 2'b11;

  localparam int BIAS = 127;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic        sign;
    logic [7:0]  e;
    logic [23:0] m;
    logic        zero;
    logic        inf;
    logic        nan;
  } fp_unp_t;
endpackage

// File: rtl/fp_divsqrt_iter_if.sv
// Issue/result bundle between the E1 operand stage, the divide/sqrt engine and the rounder.
interface fp_divsqrt_iter_if #(
  parameter int ITER = 26,
  parameter int CW   = 5
);
  logic            start;
  logic            op;
  logic [31:0]     a;
  logic [31:0]     b;
  logic            flush;
  logic            busy;
  logic [CW-1:0]   count;
  logic            done;
  logic [ITER-1:0] q;
  logic            sticky;
  logic [9:0]      exp;
  logic            sign;
  logic [1:0]      spc;

  modport master (output start, op, a, b, flush,
                  input  busy, count, done, q, sticky, exp, sign, spc);
  modport slave  (input  start, op, a, b, flush,
                  output busy, count, done, q, sticky, exp, sign, spc);
endinterface

// File: rtl/fp_unpack.sv
// Splits an IEEE single into sign/exponent/1.f mantissa; denormals read as zero.
module fp_unpack
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output fp_unp_t     u
);
  always_comb begin
    u.sign = x[31];
    u.e    = x[30:23];
    u.m    = {1'b1, x[22:0]};
    u.zero = (x[30:23] == 8'd0);
    u.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    u.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  end
endmodule

// File: rtl/fp_divsqrt_iter.sv
// Iterative restoring mantissa divide / square root, one result bit per cycle,
// feeding the normalise/round stage and driving the st_ds stall.
module fp_divsqrt_iter
  import fpu_pkg::*;
#(
  parameter int ITER = 26,
  parameter int CW   = 5
) (
  input  logic             clk,
  input  logic             clrn,
  fp_divsqrt_iter_if.slave bus
);
  localparam int RW = ITER + 2;

  fp_unp_t ua, ub;
  fp_unpack u_unp_a (.x(bus.a), .u(ua));
  fp_unpack u_unp_b (.x(bus.b), .u(ub));

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [ITER-1:0] q_r;
  logic [RW-1:0]   rem;
  logic [23:0]     den;
  logic [25:0]     rad;
  logic            op_r, sign_r, sticky_r;
  logic [9:0]      exp_r;
  logic [1:0]      spc_r;

  logic [1:0] spc_n;
  logic       sign_n;
  logic [9:0] exp_n, e_unb, e_even;

  always_comb begin
    spc_n  = SPC_NORM;
    e_unb  = {2'b00, ua.e} - 10'(BIAS);
    e_even = e_unb - {9'd0, e_unb[0]};
    if (bus.op == OP_SQRT) begin
      sign_n = ua.sign;
      exp_n  = {e_even[9], e_even[9:1]} + 10'(BIAS);
      if (ua.nan || (ua.sign && !ua.zero)) spc_n = SPC_NAN;
      else if (ua.inf)                     spc_n = SPC_INF;
      else if (ua.zero)                    spc_n = SPC_ZERO;
    end else begin
      sign_n = ua.sign ^ ub.sign;
      exp_n  = {2'b00, ua.e} - {2'b00, ub.e} + 10'(BIAS);
      if (ua.nan || ub.nan || (ua.zero && ub.zero) || (ua.inf && ub.inf)) spc_n = SPC_NAN;
      else if (ub.zero || ua.inf)                                       spc_n = SPC_INF;
      else if (ua.zero || ub.inf)                                       spc_n = SPC_ZERO;
    end
  end

  // One restoring step; sqrt pulls the next radicand bit pair into the remainder.
  logic [RW-1:0] d_trial, s_trial, s_dif, rem_n;
  logic [RW+1:0] s_sh;
  logic          bit_n;

  always_comb begin
    d_trial = {1'b0, rem[RW-2:0]} - RW'(den);
    s_sh    = {rem, rad[25:24]};
    s_trial = {q_r, 2'b01};
    s_dif   = s_sh[RW-1:0] - s_trial;
    if (op_r == OP_SQRT) begin
      bit_n = (s_sh >= (RW+2)'(s_trial));
      rem_n = bit_n ? s_dif : s_sh[RW-1:0];
    end else begin
      bit_n = !d_trial[RW-1];
      rem_n = bit_n ? {d_trial[RW-2:0], 1'b0} : {rem[RW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= S_IDLE;
      count    <= '0;
      q_r      <= '0;
      rem      <= '0;
      den      <= '0;
      rad      <= '0;
      op_r     <= 1'b0;
      sign_r   <= 1'b0;
      sticky_r <= 1'b0;
      exp_r    <= '0;
      spc_r    <= SPC_NORM;
    end else if (bus.flush) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          op_r     <= bus.op;
          sign_r   <= sign_n;
          spc_r    <= spc_n;
          q_r      <= '0;
          sticky_r <= 1'b0;
          den      <= ub.m;
          // Radicand scaled so its top bit pair is the integer part of 1.f or 2*1.f
          rad      <= e_unb[0] ? {ua.m, 2'b00} : {1'b0, ua.m, 1'b0};
          rem      <= (bus.op == OP_SQRT) ? '0 : RW'(ua.m);
          if (spc_n == SPC_NORM) begin
            exp_r <= exp_n;
            count <= CW'(ITER);
            state <= S_RUN;
          end else begin
            exp_r <= '0;
            count <= '0;
            state <= S_DONE;
          end
        end
        S_RUN: begin
          q_r   <= {q_r[ITER-2:0], bit_n};
          rem   <= rem_n;
          rad   <= {rad[23:0], 2'b00};
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            sticky_r <= |rem_n;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_RUN);
  assign bus.done   = (state == S_DONE);
  assign bus.count  = count;
  assign bus.q      = q_r;
  assign bus.sticky = sticky_r;
  assign bus.exp    = exp_r;
  assign bus.sign   = sign_r;
  assign bus.spc    = spc_r;
endmodule

// File: tb/tb_fp_divsqrt_iter.sv
// Directed bench for fp_divsqrt_iter: vector table plus flush, ignored-start and async-reset sequences.
module tb_fp_divsqrt_iter;
  import fpu_pkg::*;
  localparam int ITER = 26;
  localparam int CW   = 5;
  localparam int NV   = 22;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  always #5 clk = ~clk;

  fp_divsqrt_iter_if #(.ITER(ITER), .CW(CW)) bus();
  fp_divsqrt_iter #(.ITER(ITER), .CW(CW)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  spc;
    logic        sign;
    logic [25:0] q;
    logic [25:0] qm;
    logic [9:0]  e;
    logic        st;
  } vec_t;

  vec_t vt [NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 1; nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      tick();
      lat++;
    end
  endtask

  function automatic vec_t mk(logic op, logic [31:0] a, logic [31:0] b, logic [1:0] spc,
                              logic sign, logic [25:0] q, logic [25:0] qm, logic [9:0] e, logic st);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.spc = spc; v.sign = sign;
    v.q = q; v.qm = qm; v.e = e; v.st = st;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, n, t;
    logic seen;

    vt[0]  = mk(OP_DIV,  32'h40C00000, 32'h40000000, SPC_NORM, 1'b0, 26'h3000000, 26'h3FFFFFF, 10'd128, 1'b0);
    vt[1]  = mk(OP_DIV,  32'h3F800000, 32'h40400000, SPC_NORM, 1'b0, 26'h1555555, 26'h3FFFFFF, 10'd126, 1'b1);
    vt[2]  = mk(OP_DIV,  32'hC0C00000, 32'h40000000, SPC_NORM, 1'b1, 26'h3000000, 26'h3FFFFFF, 10'd128, 1'b0);
    vt[3]  = mk(OP_DIV,  32'h3F800000, 32'h3F800000, SPC_NORM, 1'b0, 26'h2000000, 26'h3FFFFFF, 10'd127, 1'b0);
    vt[4]  = mk(OP_DIV,  32'h3FFFFFFF, 32'h3F800000, SPC_NORM, 1'b0, 26'h3FFFFFC, 26'h3FFFFFF, 10'd127, 1'b0);
    vt[5]  = mk(OP_DIV,  32'h3F800000, 32'h3FFFFFFF, SPC_NORM, 1'b0, 26'h1000001, 26'h3FFFFFF, 10'd127, 1'b1);
    vt[6]  = mk(OP_SQRT, 32'h40800000, 32'h7FC00000, SPC_NORM, 1'b0, 26'h2000000, 26'h3FFFFFF, 10'd128, 1'b0);
    vt[7]  = mk(OP_SQRT, 32'h40000000, 32'h7FC00000, SPC_NORM, 1'b0, 26'h2C00000, 26'h3C00000, 10'd127, 1'b1);
    vt[8]  = mk(OP_SQRT, 32'h3F000000, 32'h00000000, SPC_NORM, 1'b0, 26'h2C00000, 26'h3C00000, 10'd126, 1'b1);
    vt[9]  = mk(OP_SQRT, 32'h3E800000, 32'h00000000, SPC_NORM, 1'b0, 26'h2000000, 26'h3FFFFFF, 10'd126, 1'b0);
    vt[10] = mk(OP_SQRT, 32'h41100000, 32'h00000000, SPC_NORM, 1'b0, 26'h3000000, 26'h3FFFFFF, 10'd128, 1'b0);
    vt[11] = mk(OP_DIV,  32'h3F800000, 32'h00000000, SPC_INF,  1'b0, '0, '0, '0, 1'b0);
    vt[12] = mk(OP_SQRT, 32'hBF800000, 32'h00000000, SPC_NAN,  1'b1, '0, '0, '0, 1'b0);
    vt[13] = mk(OP_DIV,  32'h00000000, 32'h00000000, SPC_NAN,  1'b0, '0, '0, '0, 1'b0);
    vt[14] = mk(OP_DIV,  32'h00000000, 32'h40A00000, SPC_ZERO, 1'b0, '0, '0, '0, 1'b0);
    vt[15] = mk(OP_DIV,  32'h7F800000, 32'h7F800000, SPC_NAN,  1'b0, '0, '0, '0, 1'b0);
    vt[16] = mk(OP_DIV,  32'h40000000, 32'h7F800000, SPC_ZERO, 1'b0, '0, '0, '0, 1'b0);
    vt[17] = mk(OP_SQRT, 32'h80000000, 32'h00000000, SPC_ZERO, 1'b1, '0, '0, '0, 1'b0);
    vt[18] = mk(OP_SQRT, 32'h7F800000, 32'h00000000, SPC_INF,  1'b0, '0, '0, '0, 1'b0);
    vt[19] = mk(OP_DIV,  32'h7FC00000, 32'h3F800000, SPC_NAN,  1'b0, '0, '0, '0, 1'b0);
    vt[20] = mk(OP_DIV,  32'h00000001, 32'h3F800000, SPC_ZERO, 1'b0, '0, '0, '0, 1'b0);
    vt[21] = mk(OP_DIV,  32'hFF800000, 32'h40000000, SPC_INF,  1'b1, '0, '0, '0, 1'b0);

    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;

    // Reset state
    #1 clrn = 1'b0;
    #2;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_q", 32'(bus.q), 0);
    chk("rst_misc", {bus.sticky, bus.exp, bus.sign, bus.spc}, 0);
    #10 clrn = 1'b1;
    tick();

    // Cycle-accurate trace of 6/2
    issue(OP_DIV, 32'h40C00000, 32'h40000000);
    for (int k = 0; k < ITER; k++) begin
      chk($sformatf("trace_busy%0d", k), 32'(bus.busy), 1);
      chk($sformatf("trace_count%0d", k), 32'(bus.count), 32'(ITER - k));
      tick();
    end
    chk("trace_done", 32'(bus.done), 1);
    chk("trace_busy_end", 32'(bus.busy), 0);
    chk("trace_count_end", 32'(bus.count), 0);
    tick();
    chk("trace_done_drop", 32'(bus.done), 0);
    chk("trace_q_hold", 32'(bus.q), 32'h3000000);
    chk("trace_exp_hold", 32'(bus.exp), 128);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      logic norm;
      norm = (vt[i].spc == SPC_NORM);
      issue(vt[i].op, vt[i].a, vt[i].b);
      wait_done(lat, nb);
      chk($sformatf("v%0d_lat", i), lat, norm ? 27 : 1);
      chk($sformatf("v%0d_busy", i), nb, norm ? 26 : 0);
      chk($sformatf("v%0d_spc", i), 32'(bus.spc), 32'(vt[i].spc));
      chk($sformatf("v%0d_sign", i), 32'(bus.sign), 32'(vt[i].sign));
      if (norm) begin
        chk($sformatf("v%0d_q", i), 32'(bus.q & vt[i].qm), 32'(vt[i].q));
        chk($sformatf("v%0d_exp", i), 32'(bus.exp), 32'(vt[i].e));
        chk($sformatf("v%0d_sticky", i), 32'(bus.sticky), 32'(vt[i].st));
      end
      tick();
      chk($sformatf("v%0d_done_drop", i), 32'(bus.done), 0);
    end

    // Flush at count 10
    issue(OP_DIV, 32'h40C00000, 32'h40000000);
    n = 0;
    while (bus.count != 5'd10 && n < 40) begin tick(); n++; end
    chk("flush_reach10", 32'(bus.count), 10);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 0);
    chk("flush_count", 32'(bus.count), 0);
    seen = 1'b0;
    for (int k = 0; k < 35; k++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      tick();
    end
    chk("flush_no_done", 32'(seen), 0);

    // Start at count 15 is ignored
    issue(OP_DIV, 32'h3F800000, 32'h40400000);
    t = 0;
    while (bus.count != 5'd15 && t < 40) begin tick(); t++; end
    chk("ign_reach15", 32'(bus.count), 15);
    bus.op = OP_SQRT; bus.a = 32'h40800000; bus.start = 1'b1;
    tick(); t++;
    bus.start = 1'b0;
    chk("ign_count14", 32'(bus.count), 14);
    while (!bus.done && t < 60) begin tick(); t++; end
    chk("ign_latency", t, 26);
    chk("ign_q", 32'(bus.q), 32'h1555555);
    chk("ign_exp", 32'(bus.exp), 126);
    chk("ign_sticky", 32'(bus.sticky), 1);
    tick();

    // Asynchronous reset mid-run
    issue(OP_DIV, 32'h40C00000, 32'h40000000);
    for (int k = 0; k < 8; k++) tick();
    #3 clrn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_q", 32'(bus.q), 0);
    chk("arst_misc", {bus.done, bus.sticky, bus.exp, bus.sign, bus.spc}, 0);
    #2 clrn = 1'b1;
    tick();
    issue(OP_DIV, 32'h3F800000, 32'h40400000);
    wait_done(lat, nb);
    chk("arst_lat", lat, 27);
    chk("arst_nbusy", nb, 26);
    chk("arst_q_after", 32'(bus.q), 32'h1555555);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
